// File: rtl/dcdl_fod_ctrl.sv
// DCDL control-word generator for the fractional-output divider.
// Accumulates FCW, scales residue by a sign-sign LMS adapted gain.
module dcdl_fod_ctrl #(
  parameter int                DCW_W     = 12,
  parameter int                FRAC_W    = 16,
  parameter int                GAIN_W    = 16,
  parameter logic [GAIN_W-1:0] GAIN_INIT = 16'h8000,
  parameter int                GAIN_STEP = 16,
  parameter int                DCW_OFST  = 0,
  parameter int                PHE_LAT   = 2
) (
  input  logic              CKIN,
  input  logic              RST,
  input  logic              EN,
  input  logic              CAL_EN,
  input  logic [FRAC_W-1:0] FCW_FRAC,
  input  logic              PHE_SIGN,
  output logic [DCW_W-1:0]  DCW,
  output logic              CARRY,
  output logic [GAIN_W-1:0] GAIN,
  output logic              CAL_ACTIVE
);

  localparam int PW = FRAC_W + GAIN_W;
  localparam int SH = PW - DCW_W;
  localparam logic [DCW_W:0] OFS = (DCW_W+1)'(DCW_OFST);
  localparam logic [DCW_W-1:0] OFS_W = DCW_W'(DCW_OFST);
  localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(GAIN_STEP);
  localparam logic [3:0] WARM_END = 4'(PHE_LAT);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic cal_d;

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0] acc_sum;
  logic [PW-1:0] prod;
  logic [DCW_W-1:0] scaled;
  logic [DCW_W:0] dcw_sum;
  logic [DCW_W-1:0] dcw_sat;
  logic [PHE_LAT-1:0] msb_sr;
  logic [PHE_LAT:0] sr_nxt;
  logic aligned_msb;
  logic [GAIN_W:0] gain_up;
  logic [GAIN_W-1:0] gain_inc, gain_dec;
  logic upd;

  assign acc_sum = {1'b0, acc} + {1'b0, FCW_FRAC};
  assign prod = PW'(acc) * PW'(GAIN);
  assign scaled = DCW_W'(prod >> SH);
  assign dcw_sum = {1'b0, scaled} + OFS;
  assign dcw_sat = dcw_sum[DCW_W] ? {DCW_W{1'b1}} : dcw_sum[DCW_W-1:0];
  assign sr_nxt = {msb_sr, acc[FRAC_W-1]};
  assign aligned_msb = msb_sr[PHE_LAT-1];
  assign gain_up = {1'b0, GAIN} + STEP;
  assign gain_inc = gain_up[GAIN_W] ? {GAIN_W{1'b1}} : gain_up[GAIN_W-1:0];
  assign gain_dec = ({1'b0, GAIN} < STEP) ? '0 : GAIN - STEP[GAIN_W-1:0];
  assign upd = CAL_ACTIVE && CAL_EN && EN;

  // Enable FSM: warm-up until the phase pipeline holds valid samples
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (EN) state_d = WARM;
      end
      WARM: begin
        if (cnt_q == WARM_END) state_d = RUN;
        else cnt_d = cnt_q + 4'd1;
      end
      RUN: ;
      default: state_d = IDLE;
    endcase
    if (!EN) begin
      state_d = IDLE;
      cnt_d = '0;
    end
    cal_d = EN && CAL_EN && (state_d == RUN);
  end

  // FSM state, warm-up counter and registered calibration permit
  always_ff @(posedge CKIN or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      CAL_ACTIVE <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      CAL_ACTIVE <= cal_d;
    end
  end

  // Phase accumulator, scaled DCW and residue-MSB alignment pipe
  always_ff @(posedge CKIN or posedge RST) begin
    if (RST) begin
      acc <= '0;
      CARRY <= 1'b0;
      DCW <= OFS_W;
      msb_sr <= '0;
    end else if (!EN) begin
      acc <= '0;
      CARRY <= 1'b0;
      DCW <= OFS_W;
      msb_sr <= '0;
    end else begin
      acc <= acc_sum[FRAC_W-1:0];
      CARRY <= acc_sum[FRAC_W];
      DCW <= dcw_sat;
      msb_sr <= sr_nxt[PHE_LAT-1:0];
    end
  end

  // Sign-sign LMS gain adaptation with saturation at both rails
  always_ff @(posedge CKIN or posedge RST) begin
    if (RST) begin
      GAIN <= GAIN_INIT;
    end else if (upd) begin
      if ((PHE_SIGN ^ aligned_msb) == 1'b0) GAIN <= gain_inc;
      else GAIN <= gain_dec;
    end
  end

endmodule
